// File: rtl/ula_seq.sv
// ula_seq -- sequential ALU, one operation per start/done transaction.
//
// Arithmetic (modo 00) and logic (modo 01) ops finish in one cycle. Multiply,
// divide, shifts and rotate (modo 10) iterate one step per cycle. modo 11 and
// unused modo-10 opcodes give a zero result with zero=1.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous reset, active low
//   start_i        request, sampled only in IDLE
//   modo_i         operation class
//   operacao_i     opcode within class
//   a_i, b_i       operands, latched on accept
//   busy_o         high from accept through the done cycle
//   done_o         one-cycle completion pulse
//   ula_out_o      result / product low / quotient
//   ula_out_hi_o   product high / remainder, 0 otherwise
//   carry_out_o, zero_o, negativo_o, overflow_o   flags, loaded with done
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// CALC  | iterating; the step taken when cnt_q==1 is the last one
// DONE  | results/flags just loaded, done_o high for this cycle only
module ula_seq #(
   parameter int WIDTH = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       modo_i,
   input  logic [2:0]       operacao_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] ula_out_o,
   output logic [WIDTH-1:0] ula_out_hi_o,
   output logic             carry_out_o,
   output logic             zero_o,
   output logic             negativo_o,
   output logic             overflow_o
);

   localparam int SW = $clog2(WIDTH + 1);
   localparam logic [SW-1:0]    CNT_W   = SW'(WIDTH);
   localparam logic [SW-1:0]    CNT_ONE = SW'(1);
   localparam logic [WIDTH-1:0] W_VAL   = WIDTH'(WIDTH);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;       // multiplicand or divisor
   logic [WIDTH-1:0] hi_q, hi_d;     // partial product high / remainder
   logic [WIDTH-1:0] lo_q, lo_d;     // multiplier / dividend->quotient / shift data
   logic             c_q, c_d;       // last bit shifted out
   logic [SW-1:0]    cnt_q, cnt_d;   // remaining iterations

   logic [WIDTH-1:0] out_q, out_d, outhi_q, outhi_d;
   logic             carry_q, carry_d, zero_q, zero_d;
   logic             neg_q, neg_d, ovf_q, ovf_d;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         out_q   <= '0;
         outhi_q <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         outhi_q <= outhi_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      logic [WIDTH-1:0] ax, ay, lg;
      logic [WIDTH:0]   ar;
      logic             sub, ar_v;
      logic [WIDTH:0]   mul_sum;
      logic [WIDTH:0]   div_r;
      logic [WIDTH-1:0] div_diff;
      logic             div_ge;
      logic [WIDTH-1:0] st_hi, st_lo;
      logic             st_c;
      logic [SW-1:0]    sh_n, rol_n;
      logic             load, r_mul, r_c, r_v;
      logic [WIDTH-1:0] r_out, r_hi;

      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      outhi_d = outhi_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      neg_d   = neg_q;
      ovf_d   = ovf_q;
      load    = 1'b0;
      r_mul   = 1'b0;
      r_c     = 1'b0;
      r_v     = 1'b0;
      r_out   = '0;
      r_hi    = '0;

      // Arithmetic: odd opcodes subtract; bit WIDTH is carry or borrow.
      sub = operacao_i[0];
      ax  = (operacao_i[2:1] == 2'b11) ? b_i : a_i;
      if (!operacao_i[2]) ay = operacao_i[1] ? ~b_i : b_i;
      else                ay = ONE;
      ar = sub ? ({1'b0, ax} - {1'b0, ay}) : ({1'b0, ax} + {1'b0, ay});
      if (sub) ar_v = (ax[WIDTH-1] != ay[WIDTH-1]) && (ar[WIDTH-1] != ax[WIDTH-1]);
      else     ar_v = (ax[WIDTH-1] == ay[WIDTH-1]) && (ar[WIDTH-1] != ax[WIDTH-1]);

      case (operacao_i)
         3'b000:  lg = a_i & b_i;
         3'b001:  lg = ~a_i;
         3'b010:  lg = ~b_i;
         3'b011:  lg = a_i | b_i;
         3'b100:  lg = a_i ^ b_i;
         3'b101:  lg = a_i & ~b_i;
         3'b110:  lg = a_i;
         default: lg = b_i;
      endcase

      sh_n  = (b_i > W_VAL) ? CNT_W : b_i[SW-1:0];
      rol_n = SW'(b_i % W_VAL);

      // One iteration step of the latched operation.
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
      div_r    = {hi_q, lo_q[WIDTH-1]};
      div_ge   = (div_r >= {1'b0, a_q});
      div_diff = div_r[WIDTH-1:0] - a_q;
      st_hi = hi_q;
      st_lo = lo_q;
      st_c  = c_q;
      case (op_q)
         3'b000: begin
            st_hi = mul_sum[WIDTH:1];
            st_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
         end
         3'b001: begin
            st_hi = div_ge ? div_diff : div_r[WIDTH-1:0];
            st_lo = {lo_q[WIDTH-2:0], div_ge};
         end
         3'b010: begin
            st_lo = {lo_q[WIDTH-2:0], 1'b0};
            st_c  = lo_q[WIDTH-1];
         end
         3'b011: begin
            st_lo = {1'b0, lo_q[WIDTH-1:1]};
            st_c  = lo_q[0];
         end
         3'b100: begin
            st_lo = {lo_q[WIDTH-1], lo_q[WIDTH-1:1]};
            st_c  = lo_q[0];
         end
         3'b101: begin
            st_lo = {lo_q[WIDTH-2:0], lo_q[WIDTH-1]};
            st_c  = 1'b0;
         end
         default: ;
      endcase

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               op_d    = operacao_i;
               state_d = S_DONE;
               load    = 1'b1;
               case (modo_i)
                  2'b00: begin
                     r_out = ar[WIDTH-1:0];
                     r_c   = ar[WIDTH];
                     r_v   = ar_v;
                  end
                  2'b01: r_out = lg;
                  2'b10: begin
                     case (operacao_i)
                        3'b000: begin
                           state_d = S_CALC;
                           load    = 1'b0;
                           a_d     = a_i;
                           hi_d    = '0;
                           lo_d    = b_i;
                           cnt_d   = CNT_W;
                        end
                        3'b001: begin
                           if (b_i == '0) begin
                              r_out = '1;
                              r_hi  = a_i;
                              r_v   = 1'b1;
                           end else begin
                              state_d = S_CALC;
                              load    = 1'b0;
                              a_d     = b_i;
                              hi_d    = '0;
                              lo_d    = a_i;
                              cnt_d   = CNT_W;
                           end
                        end
                        3'b010, 3'b011, 3'b100, 3'b101: begin
                           // Zero-length shift/rotate completes immediately.
                           if ((operacao_i == 3'b101 ? rol_n : sh_n) == '0) begin
                              r_out = a_i;
                           end else begin
                              state_d = S_CALC;
                              load    = 1'b0;
                              lo_d    = a_i;
                              c_d     = 1'b0;
                              cnt_d   = (operacao_i == 3'b101) ? rol_n : sh_n;
                           end
                        end
                        default: ;
                     endcase
                  end
                  default: ;
               endcase
            end
         end
         S_CALC: begin
            hi_d  = st_hi;
            lo_d  = st_lo;
            c_d   = st_c;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = S_DONE;
               load    = 1'b1;
               r_out   = st_lo;
               case (op_q)
                  3'b000: begin
                     r_mul = 1'b1;
                     r_hi  = st_hi;
                     r_c   = (st_hi != '0);
                     r_v   = (st_hi != '0);
                  end
                  3'b001:  r_hi = st_hi;
                  default: r_c  = st_c;
               endcase
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         out_d   = r_out;
         outhi_d = r_hi;
         carry_d = r_c;
         ovf_d   = r_v;
         neg_d   = r_out[WIDTH-1];
         zero_d  = (r_out == '0) && (!r_mul || (r_hi == '0));
      end
   end

   assign busy_o       = (state_q != S_IDLE);
   assign done_o       = (state_q == S_DONE);
   assign ula_out_o    = out_q;
   assign ula_out_hi_o = outhi_q;
   assign carry_out_o  = carry_q;
   assign zero_o       = zero_q;
   assign negativo_o   = neg_q;
   assign overflow_o   = ovf_q;

endmodule
